flappy_game_ctrl: RTL and testbench

Frame-level game sequencer for the Flappy Bird VGA peripheral.
- Takes the VGA vertical sync and the renderer's pixel-level hit flags.
- Issues one-cycle enable strobes that advance bird physics, pipe scroll and bird animation.
- Latches flap/start/pause commands from the Avalon slave.
- Tracks score and high score, and owns the game state machine.

---
 rtl/flappy_game_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
//
// Frame-level game sequencer for the Flappy Bird VGA peripheral. Once per
// frame (rising edge of the active-low VGA vertical sync) it decides which
// subsystems advance. It issues one-cycle enable strobes one clock after the
// frame tick. It latches Avalon commands until a frame consumes them, and it
// keeps the score and the high score.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   vga_vs              VGA vertical sync (active-low)
//   write/read/chipselect/address/writedata/readdata
//                       Avalon slave; address 0 write = command
//                       {pause,start,flap}. Reads return state, score,
//                       hiscore and the pending flags.
//   collide_px, ground_hit, pipe_pass
//                       hit/score events from the renderer and physics
//   phys_tick, pipe_tick, anim_tick, flap_cmd, world_reset
//                       per-frame strobes to the physics, pipe and sprite blocks
//   state, score, hiscore
//                       game status
//
// Build option
//   FLAPPY_AUTO_FLAP_EN  demo mode: the game self-starts, READY does not wait
//                        for a flap, and PLAYING gets a forced flap every
//                        AUTO_FLAP_FRAMES ticks.
//
// States
//   state    | meaning
//   ATTRACT  | title screen, bird animates, waits for start
//   READY    | world reset, waits for the first flap
//   PLAYING  | physics, pipes and animation advance every frame
//   PAUSED   | everything frozen, waits for pause toggle
//   DYING    | bird falls for DIE_FRAMES frames
//   GAMEOVER | frozen, waits for start
// -----------------------------------------------------------------------------
module flappy_game_ctrl #(
  parameter int DIE_FRAMES       = 60,
  parameter int SCORE_MAX        = 99,
  parameter int AUTO_FLAP_FRAMES = 45
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vga_vs,
  input  logic       write,
  input  logic       read,
  input  logic       chipselect,
  input  logic [1:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       collide_px,
  input  logic       ground_hit,
  input  logic       pipe_pass,
  output logic       phys_tick,
  output logic       pipe_tick,
  output logic       anim_tick,
  output logic       flap_cmd,
  output logic       world_reset,
  output logic [2:0] state,
  output logic [6:0] score,
  output logic [6:0] hiscore
);

  typedef enum logic [2:0] {
    ST_ATTRACT  = 3'd0,
    ST_READY    = 3'd1,
    ST_PLAYING  = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_DYING    = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  localparam int DIE_W = (DIE_FRAMES > 1) ? $clog2(DIE_FRAMES) : 1;

`ifdef FLAPPY_AUTO_FLAP_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             vs_q;
  logic             flap_pend_q, flap_pend_d;
  logic             start_pend_q, start_pend_d;
  logic             pause_pend_q, pause_pend_d;
  logic             hit_sticky_q, hit_sticky_d;
  logic             pass_sticky_q, pass_sticky_d;
  logic [DIE_W-1:0] die_cnt_q, die_cnt_d;
  logic [6:0]       score_q, score_d;
  logic [6:0]       hiscore_q, hiscore_d;
  logic             phys_q, phys_d;
  logic             pipe_q, pipe_d;
  logic             anim_q, anim_d;
  logic             flap_cmd_q, flap_cmd_d;
  logic             wreset_q, wreset_d;

  logic frame_tick;
  logic cmd_wr;
  logic hit_now;
  logic pass_now;
  logic use_flap;
  logic use_start;
  logic use_pause;
  logic auto_flap;

  assign frame_tick = vga_vs & ~vs_q;
  assign cmd_wr     = chipselect & write & (address == 2'd0);
  // Events on the tick cycle itself still belong to the frame being closed.
  assign hit_now    = hit_sticky_q | collide_px | ground_hit;
  assign pass_now   = pass_sticky_q | pipe_pass;

`ifdef FLAPPY_AUTO_FLAP_EN
  localparam int AF_W = (AUTO_FLAP_FRAMES > 1) ? $clog2(AUTO_FLAP_FRAMES) : 1;
  localparam logic [AF_W-1:0] AF_RELOAD = AF_W'(AUTO_FLAP_FRAMES - 1);

  logic [AF_W-1:0] af_cnt_q, af_cnt_d;

  always_comb begin
    af_cnt_d  = af_cnt_q;
    auto_flap = 1'b0;
    if (frame_tick) begin
      if (state_q == ST_PLAYING) begin
        if (af_cnt_q == '0) begin
          auto_flap = 1'b1;
          af_cnt_d  = AF_RELOAD;
        end else begin
          af_cnt_d = af_cnt_q - AF_W'(1);
        end
      end else if (state_d == ST_PLAYING) begin
        af_cnt_d = AF_RELOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) af_cnt_q <= AF_RELOAD;
    else          af_cnt_q <= af_cnt_d;
  end
`else
  assign auto_flap = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    die_cnt_d     = die_cnt_q;
    score_d       = score_q;
    hiscore_d     = hiscore_q;
    hit_sticky_d  = hit_now;
    pass_sticky_d = pass_now;
    phys_d        = 1'b0;
    pipe_d        = 1'b0;
    anim_d        = 1'b0;
    flap_cmd_d    = 1'b0;
    wreset_d      = 1'b0;
    use_flap      = 1'b0;
    use_start     = 1'b0;
    use_pause     = 1'b0;

    if (frame_tick) begin
      hit_sticky_d  = 1'b0;
      pass_sticky_d = 1'b0;
      case (state_q)
        ST_ATTRACT: begin
          anim_d    = 1'b1;
          use_pause = 1'b1;
          if (start_pend_q || AUTO_EN) begin
            use_start = 1'b1;
            wreset_d  = 1'b1;
            state_d   = ST_READY;
          end
        end
        ST_READY: begin
          anim_d    = 1'b1;
          use_pause = 1'b1;
          if (flap_pend_q || AUTO_EN) begin
            use_flap   = 1'b1;
            score_d    = '0;
            phys_d     = 1'b1;
            pipe_d     = 1'b1;
            flap_cmd_d = flap_pend_q;
            state_d    = ST_PLAYING;
          end
        end
        ST_PLAYING: begin
          phys_d     = 1'b1;
          pipe_d     = 1'b1;
          anim_d     = 1'b1;
          flap_cmd_d = flap_pend_q | auto_flap;
          use_flap   = 1'b1;
          // A hit masks both a pending pause and a same-frame pipe pass.
          if (hit_now) begin
            state_d   = ST_DYING;
            die_cnt_d = DIE_W'(DIE_FRAMES - 1);
          end else if (pause_pend_q) begin
            use_pause = 1'b1;
            state_d   = ST_PAUSED;
          end else if (pass_now && (score_q < 7'(SCORE_MAX))) begin
            score_d = score_q + 7'd1;
          end
        end
        ST_PAUSED: begin
          use_flap = 1'b1;
          if (pause_pend_q) begin
            use_pause = 1'b1;
            state_d   = ST_PLAYING;
          end
        end
        ST_DYING: begin
          phys_d    = 1'b1;
          use_flap  = 1'b1;
          use_pause = 1'b1;
          if (die_cnt_q == '0) begin
            state_d = ST_GAMEOVER;
            if (score_q > hiscore_q) hiscore_d = score_q;
          end else begin
            die_cnt_d = die_cnt_q - DIE_W'(1);
          end
        end
        ST_GAMEOVER: begin
          use_pause = 1'b1;
          if (start_pend_q) begin
            use_start = 1'b1;
            wreset_d  = 1'b1;
            state_d   = ST_READY;
          end
        end
        default: state_d = ST_ATTRACT;
      endcase
    end

    // A command write landing on the consuming cycle re-arms the bit.
    flap_pend_d  = (flap_pend_q  & ~use_flap)  | (cmd_wr & writedata[0]);
    start_pend_d = (start_pend_q & ~use_start) | (cmd_wr & writedata[1]);
    pause_pend_d = (pause_pend_q & ~use_pause) | (cmd_wr & writedata[2]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ATTRACT;
      vs_q          <= 1'b0;
      flap_pend_q   <= 1'b0;
      start_pend_q  <= 1'b0;
      pause_pend_q  <= 1'b0;
      hit_sticky_q  <= 1'b0;
      pass_sticky_q <= 1'b0;
      die_cnt_q     <= '0;
      score_q       <= '0;
      hiscore_q     <= '0;
      phys_q        <= 1'b0;
      pipe_q        <= 1'b0;
      anim_q        <= 1'b0;
      flap_cmd_q    <= 1'b0;
      wreset_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vga_vs;
      flap_pend_q   <= flap_pend_d;
      start_pend_q  <= start_pend_d;
      pause_pend_q  <= pause_pend_d;
      hit_sticky_q  <= hit_sticky_d;
      pass_sticky_q <= pass_sticky_d;
      die_cnt_q     <= die_cnt_d;
      score_q       <= score_d;
      hiscore_q     <= hiscore_d;
      phys_q        <= phys_d;
      pipe_q        <= pipe_d;
      anim_q        <= anim_d;
      flap_cmd_q    <= flap_cmd_d;
      wreset_q      <= wreset_d;
    end
  end

  always_comb begin
    readdata = 8'h00;
    case (address)
      2'd0: readdata = {5'b0, state_q};
      2'd1: readdata = {1'b0, score_q};
      2'd2: readdata = {1'b0, hiscore_q};
      2'd3: readdata = {6'b0, pause_pend_q, flap_pend_q};
      default: readdata = 8'h00;
    endcase
  end

  // Reads have no side effects, and the upper command bits are reserved.
  logic unused_inputs;
  assign unused_inputs = ^{read, writedata[7:3]};

  assign phys_tick   = phys_q;
  assign pipe_tick   = pipe_q;
  assign anim_tick   = anim_q;
  assign flap_cmd    = flap_cmd_q;
  assign world_reset = wreset_q;
  assign state       = state_q;
  assign score       = score_q;
  assign hiscore     = hiscore_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vga_vs;
  logic       write;
  logic       read;
  logic       chipselect;
  logic [1:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       collide_px;
  logic       ground_hit;
  logic       pipe_pass;
  logic       phys_tick;
  logic       pipe_tick;
  logic       anim_tick;
  logic       flap_cmd;
  logic       world_reset;
  logic [2:0] state;
  logic [6:0] score;
  logic [6:0] hiscore;

  flappy_game_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vga_vs     (vga_vs),
    .write      (write),
    .read       (read),
    .chipselect (chipselect),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .collide_px (collide_px),
    .ground_hit (ground_hit),
    .pipe_pass  (pipe_pass),
    .phys_tick  (phys_tick),
    .pipe_tick  (pipe_tick),
    .anim_tick  (anim_tick),
    .flap_cmd   (flap_cmd),
    .world_reset(world_reset),
    .state      (state),
    .score      (score),
    .hiscore    (hiscore)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [21:0] v;
  } frm_t;

  typedef struct {
    string      name;
    logic [7:0] v;
  } rd_t;

  frm_t exp_q[$];
  rd_t  rd_q[$];
  frm_t fe;
  rd_t  re;

  int   total = 0;
  int   bad   = 0;
  logic resp    = 1'b0;
  logic vs_prev = 1'b0;
  logic rd_chk  = 1'b0;
  logic rst_chk = 1'b0;
  logic done    = 1'b0;
  logic final_checked = 1'b0;

  logic [21:0] act;
  assign act = {phys_tick, pipe_tick, anim_tick, flap_cmd, world_reset, state, score, hiscore};

  // The strobes belong to the cycle after the sync rising edge is sampled.
  always @(posedge clk) begin
    resp    <= vga_vs & ~vs_prev & reset_n;
    vs_prev <= reset_n ? vga_vs : 1'b0;
  end

  always @(negedge clk) begin
    if (rst_chk) begin
      total++;
      if (act !== 22'd0 || readdata !== 8'h00) begin
        bad++;
        $display("FAIL async_reset: got outputs=%h readdata=%h required all zero", act, readdata);
      end
    end else if (reset_n) begin
      if (resp) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected: got %h required no frame", act);
        end else begin
          fe = exp_q.pop_front();
          if (act !== fe.v) begin
            bad++;
            $display("FAIL frame %s: got %h required %h (ph pi an fl wr st sc hs)", fe.name, act, fe.v);
          end
        end
      end else begin
        total++;
        if ({phys_tick, pipe_tick, anim_tick, flap_cmd, world_reset} !== 5'b0) begin
          bad++;
          $display("FAIL stray_pulse at %0t: got %b required 00000", $time,
                   {phys_tick, pipe_tick, anim_tick, flap_cmd, world_reset});
        end
      end
    end
    if (rd_chk) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL read_unexpected: got %h required no read", readdata);
      end else begin
        re = rd_q.pop_front();
        if (readdata !== re.v) begin
          bad++;
          $display("FAIL read %s: got %h required %h", re.name, readdata, re.v);
        end
      end
    end
    if (done && !final_checked) begin
      total++;
      if (exp_q.size() != 0 || rd_q.size() != 0) begin
        bad++;
        $display("FAIL leftover_expectations: got frames=%0d reads=%0d required 0 0", exp_q.size(), rd_q.size());
      end
      final_checked = 1'b1;
    end
  end

  function automatic logic [21:0] pk(input bit ph, input bit pi, input bit an, input bit fl,
                                      input bit wr, input int st, input int sc, input int hs);
    pk = {ph, pi, an, fl, wr, 3'(st), 7'(sc), 7'(hs)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expf(input string n, input logic [21:0] v);
    exp_q.push_back('{name: n, v: v});
  endtask

  // hit: 0 none, 1 collide_px, 2 ground_hit
  task automatic frame(input bit pass, input int hit);
    vga_vs = 1'b0;
    cyc();
    if (pass) begin
      pipe_pass = 1'b1;
      cyc();
      pipe_pass = 1'b0;
    end
    if (hit == 1) begin
      collide_px = 1'b1;
      cyc();
      collide_px = 1'b0;
    end else if (hit == 2) begin
      ground_hit = 1'b1;
      cyc();
      ground_hit = 1'b0;
    end
    cyc();
    vga_vs = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic wr(input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 2'd0;
    writedata  = d;
    cyc();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 8'h00;
  endtask

  task automatic rd(input string n, input logic [1:0] a, input logic [7:0] v);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    rd_q.push_back('{name: n, v: v});
    rd_chk = 1'b1;
    @(negedge clk);
    #1;
    rd_chk     = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    address    = 2'd0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    vga_vs     = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    chipselect = 1'b0;
    address    = 2'd0;
    writedata  = 8'h00;
    collide_px = 1'b0;
    ground_hit = 1'b0;
    pipe_pass  = 1'b0;
    cyc();
    rst_chk = 1'b1;
    @(negedge clk);
    #1;
    rst_chk = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // attract: animation only
    for (int i = 0; i < 3; i++) begin
      expf("attract", pk(0, 0, 1, 0, 0, 0, 0, 0));
      frame(0, 0);
    end
    rd("state_attract", 2'd0, 8'h00);

    // start, then first flap
    wr(8'h02);
    expf("start", pk(0, 0, 1, 0, 1, 1, 0, 0));
    frame(0, 0);
    rd("state_ready", 2'd0, 8'h01);
    wr(8'h01);
    expf("go_play", pk(1, 1, 1, 1, 0, 2, 0, 0));
    frame(0, 0);

    // scoring and saturation
    for (int i = 1; i <= 5; i++) begin
      expf("pass", pk(1, 1, 1, 0, 0, 2, i, 0));
      frame(1, 0);
    end
    rd("score5", 2'd1, 8'h05);
    for (int i = 6; i <= 99; i++) begin
      expf("pass_up", pk(1, 1, 1, 0, 0, 2, i, 0));
      frame(1, 0);
    end
    expf("pass_sat", pk(1, 1, 1, 0, 0, 2, 99, 0));
    frame(1, 0);
    rd("score_sat", 2'd1, 8'd99);
    rd("hiscore0", 2'd2, 8'h00);

    // pause / flap discard / resume
    wr(8'h04);
    expf("pause", pk(1, 1, 1, 0, 0, 3, 99, 0));
    frame(0, 0);
    rd("state_paused", 2'd0, 8'h03);
    wr(8'h01);
    rd("flap_pending", 2'd3, 8'h01);
    for (int i = 0; i < 10; i++) begin
      expf("paused", pk(0, 0, 0, 0, 0, 3, 99, 0));
      frame(0, 0);
    end
    rd("flap_discarded", 2'd3, 8'h00);
    wr(8'h04);
    expf("unpause", pk(0, 0, 0, 0, 0, 2, 99, 0));
    frame(0, 0);
    expf("resume_noflap", pk(1, 1, 1, 0, 0, 2, 99, 0));
    frame(0, 0);
    wr(8'h01);
    expf("flap", pk(1, 1, 1, 1, 0, 2, 99, 0));
    frame(0, 0);

    // ground hit, then asynchronous reset while dying
    expf("ground_hit", pk(1, 1, 1, 0, 0, 4, 99, 0));
    frame(0, 2);
    for (int i = 0; i < 2; i++) begin
      expf("dying_a", pk(1, 0, 0, 0, 0, 4, 99, 0));
      frame(0, 0);
    end
    reset_n = 1'b0;
    vga_vs  = 1'b0;
    rst_chk = 1'b1;
    @(negedge clk);
    #1;
    rst_chk = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    rd("hiscore_rst", 2'd2, 8'h00);

    // second game: score 3, start left pending while playing
    expf("attract2", pk(0, 0, 1, 0, 0, 0, 0, 0));
    frame(0, 0);
    wr(8'h02);
    expf("start2", pk(0, 0, 1, 0, 1, 1, 0, 0));
    frame(0, 0);
    wr(8'h01);
    expf("go_play2", pk(1, 1, 1, 1, 0, 2, 0, 0));
    frame(0, 0);
    wr(8'h02);
    for (int i = 1; i <= 3; i++) begin
      expf("pass2", pk(1, 1, 1, 0, 0, 2, i, 0));
      frame(1, 0);
    end
    expf("hit_and_pass", pk(1, 1, 1, 0, 0, 4, 3, 0));
    frame(1, 1);
    for (int i = 0; i < 60; i++) begin
      if (i == 10) wr(8'h01);
      if (i == 59) expf("die_done", pk(1, 0, 0, 0, 0, 5, 3, 3));
      else         expf("dying_b", pk(1, 0, 0, 0, 0, 4, 3, 0));
      frame(0, 0);
      if (i == 10) rd("dying_flap_discard", 2'd3, 8'h00);
    end
    rd("hiscore3", 2'd2, 8'd3);

    // pending start from PLAYING consumed in GAMEOVER
    expf("restart_pending", pk(0, 0, 0, 0, 1, 1, 3, 3));
    frame(0, 0);
    wr(8'h04);
    expf("ready_pause_ignored", pk(0, 0, 1, 0, 0, 1, 3, 3));
    frame(0, 0);
    rd("pause_cleared", 2'd3, 8'h00);
    wr(8'h01);
    expf("go_play3", pk(1, 1, 1, 1, 0, 2, 0, 3));
    frame(0, 0);

    done = 1'b1;
    for (int i = 0; i < 4 && !final_checked; i++) cyc();
    if (!final_checked) begin
      $display("FAIL final_check: got not reached required reached");
      $fatal(1, "final check");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
